mem_port_arbiter: RTL

- Shares one single-ported memory bus between the pipeline's fetch port (PCF/InstrF) and memory-stage data port (ALUResultM/WriteDataM/ReadDataM).
- Grants one port at a time, drives a valid/ready bus transaction, and returns read data plus a one-cycle ack to the granted port.
- Generates stall requests that the hazard unit ORs into StallF and the M-stage stall.
- Includes a wait-state watchdog that aborts hung transactions.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory bus between the fetch port
// and the memory-stage data port. One port is granted at a time; the granted
// port sees a one-cycle ack together with the read data on the handshake cycle.
// A wait-state watchdog forces completion of hung transactions.
//
// Build option: define MEM_ARB_FAIR_EN for round-robin arbitration in IDLE.
// Without it, the data port has fixed priority when both ports request.
module mem_port_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 255,
   parameter int CW       = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ack,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   output logic          bus_valid,
   output logic          bus_we,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic          bus_ready,
   input  logic [DW-1:0] bus_rdata,
   output logic          stall_f,
   output logic          stall_m,
   output logic          err,
   output logic          err_sticky
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_IF = 2'd1,
      GNT_D  = 2'd2
   } arbState_t;

   // Instruction returned to the fetch port when a fetch is aborted.
   localparam logic [DW-1:0] NOP_INSTR = DW'(32'h0000_0013);

   arbState_t     state;
   logic [CW-1:0] waitCnt;
   logic          timeout;
   logic          done;
   logic          idleWantsData;
   logic          grantIf;
   logic          grantD;
   logic          goIdle;

`ifdef MEM_ARB_FAIR_EN
   // 1 = the most recent grant went to the data port.
   logic          lastGntData;
`endif

   // A granted cycle with no bus_ready at the wait limit is forced to complete.
   assign timeout = bus_valid && !bus_ready && (waitCnt == CW'(MAX_WAIT));
   assign done    = bus_valid && (bus_ready || timeout);
   assign err     = timeout;

   assign if_ack  = done && (state == GNT_IF);
   assign d_ack   = done && (state == GNT_D);

   assign if_rdata = !if_ack ? '0 : (timeout ? NOP_INSTR : bus_rdata);
   assign d_rdata  = (d_ack && !bus_we && !timeout) ? bus_rdata : '0;

   // Stalls are gated by reset so an abandoned access releases the pipeline at once.
   assign stall_f = reset && if_req && !if_ack;
   assign stall_m = reset && d_req && !d_ack;

`ifdef MEM_ARB_FAIR_EN
   assign idleWantsData = d_req && (!if_req || !lastGntData);
`else
   assign idleWantsData = d_req;
`endif

   // Decide the grant/release taken on the coming edge.
   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      grantIf = 1'b0;
      grantD  = 1'b0;
      goIdle  = 1'b0;
      case (state)
         IDLE: begin
            if (idleWantsData)  grantD  = 1'b1;
            else if (if_req)    grantIf = 1'b1;
         end
         GNT_IF: begin
            if (done) begin
               if (d_req) grantD = 1'b1;
               else       goIdle = 1'b1;
            end
         end
         GNT_D: begin
            if (done) begin
               if (if_req) grantIf = 1'b1;
               else        goIdle  = 1'b1;
            end
         end
         default: goIdle = 1'b1;
      endcase
   end

   // Arbiter state, registered bus outputs and the wait-state watchdog.
   // NOTE: state uses non-blocking assignments and an asynchronous active-low reset
   // so bus_valid drops the moment reset asserts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         bus_valid  <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         waitCnt    <= '0;
         err_sticky <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
         lastGntData <= 1'b0;
`endif
      end else begin
         if (timeout) err_sticky <= 1'b1;

         if (grantD) begin
            state     <= GNT_D;
            bus_valid <= 1'b1;
            bus_we    <= d_we;
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
            waitCnt   <= '0;
`ifdef MEM_ARB_FAIR_EN
            lastGntData <= 1'b1;
`endif
         end else if (grantIf) begin
            state     <= GNT_IF;
            bus_valid <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
            waitCnt   <= '0;
`ifdef MEM_ARB_FAIR_EN
            lastGntData <= 1'b0;
`endif
         end else if (goIdle) begin
            state     <= IDLE;
            bus_valid <= 1'b0;
         end else if (bus_valid) begin
            // Granted and not done means bus_ready was low this cycle.
            waitCnt <= waitCnt + 1'b1;
         end
      end
   end

endmodule
